flash_read_responder: RTL and testbench

- Avalon-MM read-only slave that answers the flash read interface used by the audio playback controller (read / address / waitrequest / readdatavalid / readdata).
- Stands in for the flash controller in simulation and on-board bring-up. Each accepted read is served from a synchronous 1-cycle ROM port.
- Wait-state insertion, response latency and outstanding-read limit are programmable, so the initiator can be exercised under realistic stalls.

---
 rtl/flash_read_responder.sv | 148 ++++++++++++++
 tb/tb_flash_read_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_responder.sv
// Avalon-MM read-only responder that answers flash reads from a synchronous 1-cycle ROM port.
// Wait states, response latency and the outstanding-read limit are set by parameters.
module flash_read_responder #(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned RESP_DELAY  = 0,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic              CLK_50M,
  input  logic              RESET_N,
  input  logic              flash_mem_read,
  input  logic [ADDR_W-1:0] flash_mem_address,
  output logic              flash_mem_waitrequest,
  output logic              flash_mem_readdatavalid,
  output logic [DATA_W-1:0] flash_mem_readdata,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_rden,
  input  logic [DATA_W-1:0] rom_q,
  output logic [15:0]       read_count
);

  localparam logic [7:0] WaitInit = 8'(WAIT_CYCLES);
  localparam logic [3:0] PendMax  = 4'(MAX_PENDING);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e              state_q, state_d;
  logic [7:0]          stall_cnt_q, stall_cnt_d;
  logic [3:0]          pending_q;
  logic [15:0]         read_count_q;
  logic [ADDR_W-1:0]   rom_address_q;
  logic                rom_rden_q;
  logic                rom_valid_q;
  logic                rdvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                can_accept, accept, retire;
  logic                line_valid;
  logic [DATA_W-1:0]   line_data;

  // Acceptance window comes only from registered state so waitrequest never follows read.
  assign can_accept = (state_q == StStall) && (stall_cnt_q == '0) && (pending_q < PendMax);
  assign accept     = can_accept & flash_mem_read;
  assign retire     = rdvalid_q;

  assign flash_mem_waitrequest   = ~can_accept;
  assign flash_mem_readdatavalid = rdvalid_q;
  assign flash_mem_readdata      = rdata_q;
  assign rom_address             = rom_address_q;
  assign rom_rden                = rom_rden_q;
  assign read_count              = read_count_q;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (flash_mem_read) begin
          state_d     = StStall;
          stall_cnt_d = WaitInit;
        end
      end
      StStall: begin
        if (!flash_mem_read) begin
          state_d = StIdle;
        end else if (stall_cnt_q != '0) begin
          stall_cnt_d = stall_cnt_q - 8'd1;
        end else if (pending_q < PendMax) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q     <= '0;
      read_count_q  <= '0;
      rom_address_q <= '0;
      rom_rden_q    <= 1'b0;
      rom_valid_q   <= 1'b0;
    end else begin
      if (accept && !retire) begin
        pending_q <= pending_q + 4'd1;
      end else if (retire && !accept) begin
        pending_q <= pending_q - 4'd1;
      end
      if (accept) begin
        read_count_q  <= read_count_q + 16'd1;
        rom_address_q <= flash_mem_address;
      end
      rom_rden_q  <= accept;
      rom_valid_q <= rom_rden_q;
    end
  end

  // rom_valid_q marks the cycle in which rom_q carries the word for an accepted read.
  if (RESP_DELAY == 0) begin : g_bypass
    assign line_valid = rom_valid_q;
    assign line_data  = rom_q;
  end else begin : g_delay
    logic [RESP_DELAY-1:0] dly_valid_q;
    logic [DATA_W-1:0]     dly_data_q [RESP_DELAY];

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
      if (!RESET_N) begin
        dly_valid_q <= '0;
        for (int unsigned i = 0; i < RESP_DELAY; i++) begin
          dly_data_q[i] <= '0;
        end
      end else begin
        dly_valid_q[0] <= rom_valid_q;
        dly_data_q[0]  <= rom_q;
        for (int unsigned i = 1; i < RESP_DELAY; i++) begin
          dly_valid_q[i] <= dly_valid_q[i-1];
          dly_data_q[i]  <= dly_data_q[i-1];
        end
      end
    end

    assign line_valid = dly_valid_q[RESP_DELAY-1];
    assign line_data  = dly_data_q[RESP_DELAY-1];
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      rdvalid_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rdvalid_q <= line_valid;
      if (line_valid) begin
        rdata_q <= line_data;
      end
    end
  end

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed self-checking bench for flash_read_responder using three parameter sets:
// a = (WAIT 2, RESP 0, MAX 4), b = (WAIT 0, RESP 10, MAX 2), c = (WAIT 2, RESP 5, MAX 4).
module tb_flash_read_responder;

  logic CLK_50M = 1'b0;
  logic RESET_N = 1'b0;

  always #10 CLK_50M = ~CLK_50M;

  logic        rd_a = 1'b0, rd_b = 1'b0, rd_c = 1'b0;
  logic [22:0] addr_a = '0, addr_b = '0, addr_c = '0;
  logic        wr_a, wr_b, wr_c;
  logic        rdv_a, rdv_b, rdv_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [22:0] raddr_a, raddr_b, raddr_c;
  logic        rden_a, rden_b, rden_c;
  logic [31:0] q_a = '0, q_b = '0, q_c = '0;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  flash_read_responder #(
    .ADDR_W(23), .DATA_W(32), .WAIT_CYCLES(2), .RESP_DELAY(0), .MAX_PENDING(4)
  ) dut_a (
    .CLK_50M                (CLK_50M),
    .RESET_N                (RESET_N),
    .flash_mem_read         (rd_a),
    .flash_mem_address      (addr_a),
    .flash_mem_waitrequest  (wr_a),
    .flash_mem_readdatavalid(rdv_a),
    .flash_mem_readdata     (rdata_a),
    .rom_address            (raddr_a),
    .rom_rden               (rden_a),
    .rom_q                  (q_a),
    .read_count             (cnt_a)
  );

  flash_read_responder #(
    .ADDR_W(23), .DATA_W(32), .WAIT_CYCLES(0), .RESP_DELAY(10), .MAX_PENDING(2)
  ) dut_b (
    .CLK_50M                (CLK_50M),
    .RESET_N                (RESET_N),
    .flash_mem_read         (rd_b),
    .flash_mem_address      (addr_b),
    .flash_mem_waitrequest  (wr_b),
    .flash_mem_readdatavalid(rdv_b),
    .flash_mem_readdata     (rdata_b),
    .rom_address            (raddr_b),
    .rom_rden               (rden_b),
    .rom_q                  (q_b),
    .read_count             (cnt_b)
  );

  flash_read_responder #(
    .ADDR_W(23), .DATA_W(32), .WAIT_CYCLES(2), .RESP_DELAY(5), .MAX_PENDING(4)
  ) dut_c (
    .CLK_50M                (CLK_50M),
    .RESET_N                (RESET_N),
    .flash_mem_read         (rd_c),
    .flash_mem_address      (addr_c),
    .flash_mem_waitrequest  (wr_c),
    .flash_mem_readdatavalid(rdv_c),
    .flash_mem_readdata     (rdata_c),
    .rom_address            (raddr_c),
    .rom_rden               (rden_c),
    .rom_q                  (q_c),
    .read_count             (cnt_c)
  );

  // ROM contents: one marker word at 0x10, otherwise the low address byte replicated.
  function automatic logic [31:0] rom_word(input logic [22:0] a);
    if (a == 23'h000010) return 32'hA5A51234;
    return {4{a[7:0]}};
  endfunction

  always @(posedge CLK_50M) begin
    if (rden_a) q_a <= rom_word(raddr_a);
    if (rden_b) q_b <= rom_word(raddr_b);
    if (rden_c) q_c <= rom_word(raddr_c);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic release_reset();
    @(posedge CLK_50M);
    #4;
    RESET_N = 1'b1;
    tick();
  endtask

  int exp_acc[4];
  int exp_rv[4];

  // Drives dut_b: a first burst of n_first reads, then continuous reads from cycle burst_at.
  task automatic throttle_run(input string tag, input int n_first, input int burst_at,
                              input int n_total, input logic [22:0] base);
    int n_acc, n_rv, max_out;
    int acc_at[4];
    int rv_at[4];
    n_acc = 0;
    n_rv = 0;
    max_out = 0;
    for (int k = 0; k < 4; k++) begin
      acc_at[k] = -1;
      rv_at[k] = -1;
    end
    for (int c = 0; c < 60; c++) begin
      rd_b   = (n_acc < n_first) || (c >= burst_at && n_acc < n_total);
      addr_b = base + 23'(n_acc);
      if (rd_b && !wr_b) begin
        if (n_acc < 4) acc_at[n_acc] = c;
        n_acc++;
      end
      if (rdv_b) begin
        if (n_rv < 4) begin
          rv_at[n_rv] = c;
          check_eq({tag, "_data"}, rdata_b, rom_word(base + 23'(n_rv)));
        end
        n_rv++;
      end
      if (n_acc - n_rv > max_out) max_out = n_acc - n_rv;
      tick();
    end
    rd_b = 1'b0;
    check_eq({tag, "_n_acc"}, n_acc, n_total);
    check_eq({tag, "_n_rv"}, n_rv, n_total);
    check_eq({tag, "_max_pending"}, max_out, 2);
    for (int k = 0; k < n_total; k++) begin
      check_eq({tag, "_acc_cycle"}, acc_at[k], exp_acc[k]);
      check_eq({tag, "_rv_cycle"}, rv_at[k], exp_rv[k]);
    end
  endtask

  initial begin
    int n_acc, n_rv, last_acc, n_rden, n_rvc, rv_cycle;

    release_reset();
    check_eq("init_waitreq", wr_a, 1'b1);
    check_eq("init_rdvalid", rdv_a, 1'b0);
    check_eq("init_count", cnt_a, 16'd0);

    // Single read at 0x10: waitrequest low only in cycle 3, response 3 cycles later.
    rd_a = 1'b1;
    addr_a = 23'h000010;
    for (int i = 0; i < 4; i++) begin
      check_eq("single_waitreq", wr_a, (i < 3) ? 1'b1 : 1'b0);
      if (i < 3) tick();
    end
    tick();
    rd_a = 1'b0;
    check_eq("single_rden_on", rden_a, 1'b1);
    check_eq("single_rom_addr", raddr_a, 23'h000010);
    check_eq("single_rdv_early", rdv_a, 1'b0);
    tick();
    check_eq("single_rden_off", rden_a, 1'b0);
    check_eq("single_rdv_early2", rdv_a, 1'b0);
    tick();
    check_eq("single_rdv", rdv_a, 1'b1);
    check_eq("single_data", rdata_a, 32'hA5A51234);
    tick();
    check_eq("single_rdv_pulse", rdv_a, 1'b0);
    check_eq("single_data_hold", rdata_a, 32'hA5A51234);
    check_eq("single_count", cnt_a, 16'd1);

    // Streaming 0..7 with read held: acceptances 4 cycles apart, data in order.
    RESET_N = 1'b0;
    release_reset();
    rd_a = 1'b1;
    addr_a = '0;
    n_acc = 0;
    n_rv = 0;
    last_acc = 0;
    for (int c = 0; c < 80 && n_rv < 8; c++) begin
      if (rdv_a) begin
        check_eq("stream_data", rdata_a, rom_word(23'(n_rv)));
        n_rv++;
      end
      if (rd_a && !wr_a) begin
        if (n_acc > 0) check_eq("stream_gap", c - last_acc, 4);
        last_acc = c;
        n_acc++;
      end
      tick();
      if (n_acc == 8) rd_a = 1'b0;
      else addr_a = 23'(n_acc);
    end
    check_eq("stream_n_rv", n_rv, 8);
    check_eq("stream_count", cnt_a, 16'd8);

    // Withdrawn request: read drops while stalled, nothing is transferred.
    rd_a = 1'b1;
    addr_a = 23'h000033;
    tick();
    check_eq("withdraw_stall", wr_a, 1'b1);
    rd_a = 1'b0;
    n_rden = 0;
    n_rvc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_rden += int'(rden_a);
      n_rvc += int'(rdv_a);
    end
    check_eq("withdraw_rden", n_rden, 0);
    check_eq("withdraw_rdv", n_rvc, 0);
    check_eq("withdraw_count", cnt_a, 16'd8);
    // Back in IDLE: a fresh read needs the full wait-state sequence again.
    rd_a = 1'b1;
    addr_a = 23'h000004;
    for (int i = 0; i < 4; i++) begin
      check_eq("withdraw_idle_waitreq", wr_a, (i < 3) ? 1'b1 : 1'b0);
      if (i < 3) tick();
    end
    tick();
    rd_a = 1'b0;
    repeat (3) tick();
    check_eq("withdraw_next_data", rdata_a, 32'h04040404);
    check_eq("withdraw_next_count", cnt_a, 16'd9);

    // Reset asserted mid-stall takes effect within the same cycle.
    rd_a = 1'b1;
    addr_a = 23'h000020;
    tick();
    tick();
    #2;
    RESET_N = 1'b0;
    #1;
    check_eq("rst_waitreq", wr_a, 1'b1);
    check_eq("rst_rdvalid", rdv_a, 1'b0);
    check_eq("rst_rdata", rdata_a, 32'h0);
    check_eq("rst_count", cnt_a, 16'd0);
    check_eq("rst_rden", rden_a, 1'b0);
    check_eq("rst_rom_addr", raddr_a, 23'h0);
    rd_a = 1'b0;
    release_reset();

    // Throttle: third acceptance must wait for the first response.
    exp_acc = '{1, 3, 15, 0};
    exp_rv  = '{14, 16, 28, 0};
    throttle_run("thr", 3, 1000, 3, 23'h000050);
    // Accept and retire in the same cycle leave pending at 1: C at 16, D waits for B's retire.
    exp_acc = '{1, 14, 16, 28};
    exp_rv  = '{14, 27, 29, 41};
    throttle_run("thr_coinc", 1, 13, 4, 23'h000060);

    // Reset with two reads in flight: those responses are dropped.
    rd_c = 1'b1;
    addr_c = 23'h000070;
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 2; c++) begin
      if (rd_c && !wr_c) begin
        check_eq("inflight_acc_cycle", c, (n_acc == 0) ? 3 : 7);
        n_acc++;
      end
      tick();
      if (n_acc == 2) rd_c = 1'b0;
      else addr_c = 23'h000070 + 23'(n_acc);
    end
    check_eq("inflight_n_acc", n_acc, 2);
    tick();
    #2;
    RESET_N = 1'b0;
    release_reset();
    n_rvc = 0;
    for (int i = 0; i < 30; i++) begin
      n_rvc += int'(rdv_c);
      tick();
    end
    check_eq("inflight_dropped", n_rvc, 0);
    check_eq("inflight_count_rst", cnt_c, 16'd0);

    // Top-of-range address completes normally after the reset.
    rd_c = 1'b1;
    addr_c = 23'h7FFFFF;
    rv_cycle = -1;
    n_acc = 0;
    for (int c = 0; c < 25; c++) begin
      if (rd_c && !wr_c) begin
        check_eq("top_acc_cycle", c, 3);
        n_acc++;
      end
      if (rdv_c) begin
        rv_cycle = c;
        check_eq("top_data", rdata_c, 32'hFFFFFFFF);
      end
      tick();
      if (n_acc != 0) rd_c = 1'b0;
    end
    check_eq("top_rv_cycle", rv_cycle, 11);
    check_eq("top_count", cnt_c, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
